// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the multicycle CPU.
//   - opcode and ALU function codes
//   - FSM state enum
//   - instruction field bit positions
package cpu_pkg;

  // Opcodes, ir[15:12]. Values 0..7 are ALU ops; bits [14:12] select the function.
  localparam logic [3:0] OP_LI   = 4'h8;
  localparam logic [3:0] OP_J    = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JNZ  = 4'hB;
  localparam logic [3:0] OP_JAL  = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU function codes
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_NOT  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_NEGA = 3'b110;
  localparam logic [2:0] ALU_NEGB = 3'b111;

  // Instruction fields
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int FN_HI   = 14;
  localparam int FN_LO   = 12;
  localparam int RA_HI   = 11;
  localparam int RA_LO   = 8;
  localparam int RB_HI   = 7;
  localparam int RB_LO   = 4;
  localparam int RD_HI   = 3;
  localparam int RD_LO   = 0;
  localparam int IMM_HI  = 11;
  localparam int IMM_LO  = 4;
  localparam int ADDR_HI = 11;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    OUTW  = 2'd2,
    HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_mc_if.sv
// cpu_mc_if: instruction fetch bus and output port of cpu_mc.
//   imem_req/imem_addr -> , imem_ack/imem_rdata <-   (fetch handshake)
//   out_valid/out_data -> , out_ready <-             (output handshake)
// master = core side, slave = memory / sink side.
interface cpu_mc_if #(
  parameter int PC_W   = 10,
  parameter int DATA_W = 8
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output imem_req, imem_addr, out_data, out_valid,
    input  imem_ack, imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_data, out_valid,
    output imem_ack, imem_rdata, out_ready
  );
endinterface

// File: rtl/cpu_mc_ret_stack.sv
// ret_stack: return-address LIFO.
//   clk, reset (async, active low)
//   push/din : store din on top (ignored when full)
//   pop      : drop top entry (ignored when empty)
//   dout     : current top entry (0 when empty)
//   full, empty : occupancy flags
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] cnt;
  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_idx, top_idx;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign wr_idx  = AW'(cnt);
  assign top_idx = AW'(cnt - CW'(1));
  assign dout    = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Storage needs no reset: entries are only read below cnt.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= din;
  end
endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multicycle CPU top.
//   clk, reset (async, active low)
//   bus       : cpu_mc_if.master (instruction fetch + output port)
//   halted    : core sits in HALT
//   stack_err : sticky return-stack overflow/underflow
// FETCH -> EXEC -> (FETCH | OUTW | HALT); OUTW -> FETCH on out handshake.
module cpu_mc
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  cpu_mc_if.master bus,
  output logic     halted,
  output logic     stack_err
);
  state_e            state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt, pc_inc, tgt;
  logic [15:0]       ir;
  logic              z;
  logic [DATA_W-1:0] rf [16];
  logic [DATA_W-1:0] out_q;
  logic              err_q;

  // decoded fields
  logic [3:0]        op, ra, rb, rd;
  logic [2:0]        fn;
  logic [7:0]        imm8;
  logic [11:0]       addr12;
  logic [DATA_W-1:0] a, b, alu_y, imm_ext;
  logic [DATA_W+7:0] imm_wide;

  // control
  logic              ir_we, rf_we, z_we, out_we, err_set, push, pop;
  logic [DATA_W-1:0] rf_wd;
  logic [PC_W-1:0]   stk_dout;
  logic              stk_full, stk_empty;

  assign op       = ir[OP_HI:OP_LO];
  assign fn       = ir[FN_HI:FN_LO];
  assign ra       = ir[RA_HI:RA_LO];
  assign rb       = ir[RB_HI:RB_LO];
  assign rd       = ir[RD_HI:RD_LO];
  assign imm8     = ir[IMM_HI:IMM_LO];
  assign addr12   = ir[ADDR_HI:0];
  assign tgt      = addr12[PC_W-1:0];
  assign pc_inc   = pc + PC_W'(1);
  // zero-extend or truncate imm8 to DATA_W without width-dependent branches
  assign imm_wide = {{DATA_W{1'b0}}, imm8};
  assign imm_ext  = imm_wide[DATA_W-1:0];
  // r0 is never written, so it always reads 0
  assign a        = rf[ra];
  assign b        = rf[rb];

  always_comb begin
    alu_y = a;
    case (fn)
      ALU_PASS: alu_y = a;
      ALU_NOT:  alu_y = ~a;
      ALU_ADD:  alu_y = a + b;
      ALU_SUB:  alu_y = a - b;
      ALU_AND:  alu_y = a & b;
      ALU_OR:   alu_y = a | b;
      ALU_NEGA: alu_y = -a;
      ALU_NEGB: alu_y = -b;
      default:  alu_y = a;
    endcase
  end

  ret_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    rf_wd     = alu_y;
    z_we      = 1'b0;
    out_we    = 1'b0;
    err_set   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    case (state)
      FETCH: begin
        if (bus.imem_ack) begin
          ir_we     = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        pc_nxt    = pc_inc;
        state_nxt = FETCH;
        case (op)
          OP_LI: begin
            rf_we = (rd != 4'd0);
            rf_wd = imm_ext;
          end
          OP_J:   pc_nxt = tgt;
          OP_JZ:  if (z)  pc_nxt = tgt;
          OP_JNZ: if (!z) pc_nxt = tgt;
          OP_JAL: begin
            if (stk_full) begin
              pc_nxt    = pc;
              err_set   = 1'b1;
              state_nxt = HALT;
            end else begin
              push   = 1'b1;
              pc_nxt = tgt;
            end
          end
          OP_RET: begin
            if (stk_empty) begin
              pc_nxt    = pc;
              err_set   = 1'b1;
              state_nxt = HALT;
            end else begin
              pop    = 1'b1;
              pc_nxt = stk_dout;
            end
          end
          OP_OUT: begin
            out_we    = 1'b1;
            state_nxt = OUTW;
          end
          OP_HALT: state_nxt = HALT;
          default: begin // ALU ops, op[3] == 0
            rf_we = (rd != 4'd0);
            z_we  = 1'b1;
          end
        endcase
      end
      OUTW: begin
        if (bus.out_ready) state_nxt = FETCH;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
      z     <= 1'b0;
      out_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (ir_we)   ir <= bus.imem_rdata;
      if (rf_we)   rf[rd] <= rf_wd;
      if (z_we)    z <= (alu_y == '0);
      if (out_we)  out_q <= a;
      if (err_set) err_q <= 1'b1;
    end
  end

  // Reset forces state to FETCH; gate req so it drops the moment reset asserts.
  assign bus.imem_req  = (state == FETCH) && reset;
  assign bus.imem_addr = pc;
  assign bus.out_valid = (state == OUTW);
  assign bus.out_data  = out_q;
  assign halted        = (state == HALT);
  assign stack_err     = err_q;
endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: directed self-checking bench for cpu_mc.
// Inputs are driven 1 time unit after posedge; outputs and handshakes are sampled on negedge.
module tb_cpu_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ack_en = 1'b1;
  logic halted, stack_err;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fbase, obase;

  logic [15:0] mem [1024];
  logic [9:0]  flog[$];
  int          ftime[$];
  logic [7:0]  olog[$];
  logic [9:0]  ef[$];
  logic [7:0]  eo[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_mc_if #(.PC_W(10), .DATA_W(8)) bus ();

  assign bus.imem_ack   = ack_en & bus.imem_req;
  assign bus.imem_rdata = mem[bus.imem_addr];

  cpu_mc #(.DATA_W(8), .PC_W(10), .STACK_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus),
    .halted    (halted),
    .stack_err (stack_err)
  );

  // handshakes seen at negedge complete on the following posedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.imem_req && bus.imem_ack) begin
        flog.push_back(bus.imem_addr);
        ftime.push_back(cyc);
      end
      if (bus.out_valid && bus.out_ready) olog.push_back(bus.out_data);
    end
  end

  function automatic logic [15:0] e_li(input logic [3:0] rd, input logic [7:0] imm);
    return {4'h8, imm, rd};
  endfunction
  function automatic logic [15:0] e_alu(input logic [2:0] f, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rd);
    return {1'b0, f, ra, rb, rd};
  endfunction
  function automatic logic [15:0] e_br(input logic [3:0] op, input logic [11:0] ad);
    return {op, ad};
  endfunction
  function automatic logic [15:0] e_out(input logic [3:0] ra);
    return {4'hE, ra, 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'hF000;
  endtask

  task automatic start_prog(input logic ack, input logic rdy);
    rst_n = 1'b0;
    ack_en = ack;
    bus.out_ready = rdy;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fbase = flog.size();
    obase = olog.size();
  endtask

  task automatic run_to_halt(input string tag, input int maxc);
    int n = 0;
    while (!halted && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, halted, 1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.out_valid, 1);
  endtask

  task automatic chk_fetch(input string tag);
    chk({tag, "_len"}, flog.size() - fbase, ef.size());
    for (int i = 0; i < ef.size(); i++)
      if (fbase + i < flog.size()) chk($sformatf("%s_%0d", tag, i), flog[fbase+i], ef[i]);
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_len"}, olog.size() - obase, eo.size());
    for (int i = 0; i < eo.size(); i++)
      if (obase + i < olog.size()) chk($sformatf("%s_%0d", tag, i), olog[obase+i], eo[i]);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    clear_mem();

    // ---- reset state
    #12;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", stack_err, 0);
    chk("rst_addr", bus.imem_addr, 0);

    // ---- ALU ops, z flag, JZ/JNZ, r0
    clear_mem();
    mem[0]     = e_li(1, 8'h05);
    mem[1]     = e_li(2, 8'h05);
    mem[2]     = e_alu(3'b011, 1, 2, 3);   // r3 = 5-5 = 0, z=1
    mem[3]     = e_br(4'hA, 12'h020);      // JZ taken
    mem[10'h20] = e_out(3);
    mem[10'h21] = e_li(5, 8'hFF);
    mem[10'h22] = e_li(6, 8'h01);
    mem[10'h23] = e_alu(3'b010, 5, 6, 7);  // 0xFF+1 = 0, z=1
    mem[10'h24] = e_br(4'hA, 12'h030);
    mem[10'h30] = e_out(7);
    mem[10'h31] = e_li(8, 8'h3C);
    mem[10'h32] = e_li(9, 8'h0F);
    mem[10'h33] = e_alu(3'b100, 8, 9, 10); // 0x0C, z=0
    mem[10'h34] = e_br(4'hB, 12'h040);     // JNZ taken
    mem[10'h40] = e_alu(3'b101, 8, 9, 11); // 0x3F
    mem[10'h41] = e_alu(3'b001, 8, 0, 12); // ~0x3C = 0xC3
    mem[10'h42] = e_alu(3'b110, 9, 0, 13); // -0x0F = 0xF1
    mem[10'h43] = e_alu(3'b111, 8, 8, 14); // -0x3C = 0xC4
    mem[10'h44] = e_out(10);
    mem[10'h45] = e_out(11);
    mem[10'h46] = e_out(12);
    mem[10'h47] = e_out(13);
    mem[10'h48] = e_out(14);
    mem[10'h49] = e_br(4'hA, 12'h000);     // z=0: not taken
    mem[10'h4A] = e_li(0, 8'h77);          // ignored
    mem[10'h4B] = e_out(0);
    start_prog(1'b1, 1'b1);
    run_to_halt("alu_halt", 200);
    ef = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h020, 10'h021, 10'h022, 10'h023,
           10'h024, 10'h030, 10'h031, 10'h032, 10'h033, 10'h034, 10'h040, 10'h041,
           10'h042, 10'h043, 10'h044, 10'h045, 10'h046, 10'h047, 10'h048, 10'h049,
           10'h04A, 10'h04B, 10'h04C};
    chk_fetch("alu_fetch");
    eo = '{8'h00, 8'h00, 8'h0C, 8'h3F, 8'hC3, 8'hF1, 8'hC4, 8'h00};
    chk_out("alu_out");
    chk("alu_cpi", ftime[fbase+1] - ftime[fbase], 2);
    chk("alu_err", stack_err, 0);
    chk("alu_halt_req", bus.imem_req, 0);

    // ---- fetch stall
    clear_mem();
    mem[0] = e_li(1, 8'h11);
    mem[1] = e_out(1);
    start_prog(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_req_%0d", i), bus.imem_req, 1);
      chk($sformatf("stall_addr_%0d", i), bus.imem_addr, 0);
    end
    @(posedge clk);
    #1 ack_en = 1'b1;
    run_to_halt("stall_halt", 50);
    ef = '{10'h000, 10'h001, 10'h002};
    chk_fetch("stall_fetch");
    eo = '{8'h11};
    chk_out("stall_out");

    // ---- call/return
    clear_mem();
    mem[0] = e_li(1, 8'h11);
    mem[1] = e_li(2, 8'h22);
    mem[2] = e_li(3, 8'h33);
    mem[3] = e_br(4'hC, 12'h040);
    mem[4] = e_out(1);
    mem[10'h40] = 16'hD000;
    start_prog(1'b1, 1'b1);
    run_to_halt("call_halt", 50);
    ef = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h040, 10'h004, 10'h005};
    chk_fetch("call_fetch");
    eo = '{8'h11};
    chk_out("call_out");
    chk("call_err", stack_err, 0);

    // ---- nested to depth 4
    clear_mem();
    mem[0]      = e_br(4'hC, 12'h010);
    mem[10'h10] = e_br(4'hC, 12'h020);
    mem[10'h11] = 16'hD000;
    mem[10'h20] = e_br(4'hC, 12'h030);
    mem[10'h21] = 16'hD000;
    mem[10'h30] = e_br(4'hC, 12'h040);
    mem[10'h31] = 16'hD000;
    mem[10'h40] = 16'hD000;
    start_prog(1'b1, 1'b1);
    run_to_halt("nest_halt", 100);
    ef = '{10'h000, 10'h010, 10'h020, 10'h030, 10'h040, 10'h031, 10'h021, 10'h011, 10'h001};
    chk_fetch("nest_fetch");
    chk("nest_err", stack_err, 0);

    // ---- fifth JAL overflows
    mem[10'h40] = e_br(4'hC, 12'h050);
    start_prog(1'b1, 1'b1);
    run_to_halt("ovf_halt", 100);
    ef = '{10'h000, 10'h010, 10'h020, 10'h030, 10'h040};
    chk_fetch("ovf_fetch");
    chk("ovf_err", stack_err, 1);
    chk("ovf_req", bus.imem_req, 0);
    chk("ovf_pc", bus.imem_addr, 10'h040);

    // ---- RET on empty stack
    clear_mem();
    mem[0] = 16'hD000;
    start_prog(1'b1, 1'b1);
    chk("unf_err_clr", stack_err, 0);
    run_to_halt("unf_halt", 20);
    chk("unf_err", stack_err, 1);
    chk("unf_pc", bus.imem_addr, 0);
    chk("unf_req", bus.imem_req, 0);

    // ---- output handshake with back-pressure
    clear_mem();
    mem[0] = e_li(4, 8'hA5);
    mem[1] = e_out(4);
    start_prog(1'b1, 1'b0);
    wait_valid("hs_valid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hs_hold_v_%0d", i), bus.out_valid, 1);
      chk($sformatf("hs_hold_d_%0d", i), bus.out_data, 8'hA5);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hs_valid_drop", bus.out_valid, 0);
    run_to_halt("hs_halt", 20);
    ef = '{10'h000, 10'h001, 10'h002};
    chk_fetch("hs_fetch");
    eo = '{8'hA5};
    chk_out("hs_out");
    chk("hs_data_hold", bus.out_data, 8'hA5);

    // ---- async reset in OUTW, then in FETCH
    start_prog(1'b1, 1'b0);
    wait_valid("rsto_valid");
    #2 rst_n = 1'b0;
    #1;
    chk("rsto_valid_low", bus.out_valid, 0);
    chk("rsto_req_low", bus.imem_req, 0);
    chk("rsto_data", bus.out_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    fbase = flog.size();
    obase = olog.size();
    run_to_halt("rsto_halt", 30);
    ef = '{10'h000, 10'h001, 10'h002};
    chk_fetch("rsto_fetch");
    eo = '{8'hA5};
    chk_out("rsto_out");

    start_prog(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("rstf_req_hi", bus.imem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstf_req_low", bus.imem_req, 0);
    chk("rstf_halted", halted, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_mc.md
Name: cpu_mc

Overview:
Parametrised multicycle successor to the single-cycle CPU top. It keeps the datapath/control split and the z-flag ALU model. New features:
- FSM-sequenced fetch over an external instruction memory with req/ack handshake.
- Hardware return-address stack for JAL/RET.
- Handshaked output port.
- HALT state with sticky stack-error reporting.

Sits at the top of the processor, between the instruction ROM/bus and the peripheral sink.

Parameters:
DATA_W, 8, register/ALU width; arithmetic modulo 2^DATA_W.
PC_W, 10, program counter width, must be <= 12.
STACK_DEPTH, 4, return-address stack entries, must be >= 1.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
imem_req  out  1  fetch request.
imem_addr  out  PC_W  fetch address (= PC).
imem_ack  in  1  fetch data valid this cycle.
imem_rdata  in  16  instruction word.
out_data  out  DATA_W  output port data.
out_valid  out  1  output data valid.
out_ready  in  1  sink accepts.
halted  out  1  core in HALT state.
stack_err  out  1  sticky; stack overflow or underflow occurred.

Behaviour:
- Reset (reset=0, async): PC=0, all regs=0, z=0, stack empty, state=FETCH, ir=0.
  - Outputs during/after reset: imem_req=0, out_valid=0, out_data=0, halted=0, stack_err=0.
  - Reset mid-handshake abandons it; no write occurs.
- Register file: 16 x DATA_W, 2 reads, 1 write. r0 reads 0; writes to r0 are ignored.
- ISA (16-bit, op=[15:12]):
  - 0aaa = ALU: rd[3:0] = ra[11:8] OP(aaa) rb[7:4]; z updated.
  - 1000 LI: rd[3:0] = zero-extended imm8 [11:4], truncated if DATA_W<8; z unchanged.
  - 1001 J: PC = addr[PC_W-1:0].
  - 1010 JZ / 1011 JNZ: jump if z=1 / z=0, else PC+1.
  - 1100 JAL: push PC+1, jump.
  - 1101 RET: PC = pop.
  - 1110 OUT: out_data = reg[ra].
  - 1111 HALT.
- ALU codes:
  - 000 A, 001 ~A, 010 A+B, 011 A-B, 100 A&B, 101 A|B, 110 -A, 111 -B.
  - Carry is discarded; z=1 iff result==0.
- FSM:
  - FETCH:
    - imem_req=1, imem_addr=PC.
    - On imem_ack: ir <= imem_rdata, go to EXEC.
    - Without ack: hold req and addr stable indefinitely.
  - EXEC: one cycle. Executes ir; PC <= PC+1 (wraps modulo 2^PC_W) or target. Next state:
    - OUT: latch out_data, go to OUTW.
    - HALT or stack error: go to HALT.
    - Otherwise: FETCH.
  - OUTW:
    - out_valid=1 with out_data stable.
    - On out_valid&&out_ready: out_valid <= 0 next cycle, go to FETCH.
  - HALT: terminal until reset. halted=1, imem_req=0.
- Throughput: minimum 2 cycles/instruction when ack is returned in the request cycle. OUT adds at least 1 cycle.
- Stack:
  - JAL when full: no push, PC unchanged, stack_err=1, go to HALT.
  - RET when empty: same handling.
  - Push to the last free slot is legal.
  - Each instruction does at most one push or pop, so there is no simultaneous push/pop.
- out_data holds its last value after the handshake.
- JZ/JNZ in the instruction right after an ALU op sees the updated z.

Decomposition:
- Package cpu_pkg: opcode constants, ALU code constants, FSM state enum (FETCH, EXEC, OUTW, HALT), instruction field bit positions.
- Sub-module ret_stack: LIFO with params DEPTH and W=PC_W.
  - Ports: push, pop, din, dout, full, empty.
  - Same clk/reset.
- ALU and register file stay inline in the datapath.

Test Plan:
- ALU and z: LI r1,5; LI r2,5; SUB r3=r1-r2; JZ 0x20 -> r3=0, z=1, next fetch address 0x20. ADD 0xFF+0x01 (DATA_W=8) -> 0x00, z=1.
- Fetch stall: imem_ack held low 5 cycles -> imem_req=1 and imem_addr constant throughout; no PC or register change.
- Call/return: JAL 0x40 at PC=3, then RET at 0x40 -> fetch sequence 3, 0x40, 4.
  - Nested to depth 4 returns in LIFO order.
  - A 5th JAL -> stack_err=1, halted=1, imem_req=0.
- RET on an empty stack right after reset -> stack_err=1, halted=1, PC unchanged.
- Output handshake: LI r4,0xA5; OUT r4 with out_ready low 3 cycles -> out_valid=1, out_data=0xA5 stable; one transfer when ready=1; next fetch follows.
- Reset asserted mid-OUTW and mid-FETCH -> out_valid=0 and imem_req=0 immediately (async). After release, fetch starts at address 0.
